adf4159_spi_rx: RTL and testbench

Receive-side model and monitor of the ADF4159 3-wire serial load interface. Oversamples `spi_clk`/`spi_data`/`spi_le` in the system clock domain, deserialises 32-bit words MSB first and latches each word on the rising edge of LE. Decodes the control bits into a banked register file and applies the chip's double-buffering rule so the active INT/FRAC/reference fields update only on an R0 write. Sits in the bench/loopback path opposite the PLL configuration controller, for self-check and readback of what the synthesizer actually received.

---
 rtl/adf4159_spi_rx_pkg.sv | 50 +++++
 rtl/adf4159_spi_rx_if.sv | 11 +
 rtl/adf4159_spi_rx_deser.sv | 66 ++++++
 rtl/adf4159_spi_rx.sv | 108 ++++++++++
 tb/tb_adf4159_spi_rx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adf4159_spi_rx_pkg.sv
// ADF4159 register map: addresses, bank-select bits, field positions, power-up slot set.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package adf4159_pkg;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam int NUM_SLOTS = 11;
  localparam logic [3:0] SLOT_R4_B1 = 4'd8;
  localparam logic [3:0] SLOT_R5_B1 = 4'd9;
  localparam logic [3:0] SLOT_R6_B1 = 4'd10;

  localparam int BANK_BIT_R4  = 6;
  localparam int BANK_BIT_R56 = 23;

  localparam int INT_LSB     = 15;
  localparam int INT_MSB     = 26;
  localparam int FRAC_HI_LSB = 3;
  localparam int FRAC_HI_MSB = 14;
  localparam int FRAC_LO_LSB = 15;
  localparam int FRAC_LO_MSB = 27;
  localparam int REF_DBL_BIT = 20;
  localparam int RCNT_LSB    = 15;
  localparam int RCNT_MSB    = 19;
  localparam int PRESC_BIT   = 22;

  // Slots 3..10 must all be seen before the chip counts as initialised.
  localparam logic [NUM_SLOTS-1:0] PWRUP_MASK = 11'b111_1111_1000;

  // Map a received word onto its register-file slot (address plus bank bit).
  function automatic logic [3:0] slot_of(input logic [31:0] w);
    logic [2:0] a;
    a = w[2:0];
    slot_of = {1'b0, a};
    if (a == R4 && w[BANK_BIT_R4])
      slot_of = SLOT_R4_B1;
    else if (a == R5 && w[BANK_BIT_R56])
      slot_of = SLOT_R5_B1;
    else if (a == R6 && w[BANK_BIT_R56])
      slot_of = SLOT_R6_B1;
  endfunction

endpackage

// File: rtl/adf4159_spi_rx_if.sv
// ADF4159 3-wire serial load pins (clock, data, load enable).
// Latency: none, plain wires.
// Backpressure: none, the receiver cannot stall the pins.
interface adf4159_spi_rx_if;
  logic spi_clk;
  logic spi_data;
  logic spi_le;

  modport master (output spi_clk, output spi_data, output spi_le);
  modport slave  (input  spi_clk, input  spi_data, input  spi_le);
endinterface

// File: rtl/adf4159_spi_rx_deser.sv
// Synchronise the SPI pins, detect edges, shift 32-bit words MSB first.
// Latency: pin change to detected edge SYNC_STAGES+1 clk cycles.
// Backpressure: none; the latch strobe is a single-cycle pulse.
module adf4159_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  adf4159_spi_rx_if.slave  spi,
  output logic [31:0]      word,
  output logic             cnt_ok,
  output logic             cnt_zero,
  output logic             latch
);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync, le_sync;
  logic                   clk_prev, le_prev;
  logic [31:0]            shreg;
  logic [5:0]             cnt;
  logic                   clk_s, dat_s, le_s;
  logic                   clk_rise, le_rise, le_fall;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign le_rise  = le_s & ~le_prev;
  assign le_fall  = ~le_s & le_prev;

  // Synchroniser chains plus one delay flop per line for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
      le_sync  <= '0;
      clk_prev <= 1'b0;
      le_prev  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], spi.spi_data};
      le_sync  <= {le_sync[SYNC_STAGES-2:0], spi.spi_le};
      clk_prev <= clk_s;
      le_prev  <= le_s;
    end
  end

  // Shift on clock rises while LE is low (this also blocks a shift coincident
  // with an LE rise); count saturates so over-long frames stay malformed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (le_fall) begin
      cnt <= '0;
    end else if (clk_rise && !le_s) begin
      shreg <= {shreg[30:0], dat_s};
      cnt   <= (cnt == 6'd63) ? 6'd63 : cnt + 6'd1;
    end
  end

  assign word     = shreg;
  assign cnt_ok   = (cnt == 6'd32);
  assign cnt_zero = (cnt == 6'd0);
  assign latch    = le_rise;

endmodule

// File: rtl/adf4159_spi_rx.sv
// ADF4159 serial-load receiver: banked register file, double-buffered active fields, status.
// Latency: LE rise detected in cycle t -> slot/fields/pulses at the t+1 edge; rd_data 1 cycle.
// Backpressure: none; every LE rise is judged and answered immediately.
module adf4159_spi_rx
  import adf4159_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  adf4159_spi_rx_if.slave  spi,
  input  logic [3:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             word_valid,
  output logic [31:0]      word_data,
  output logic             frame_err,
  output logic             init_done,
  output logic             freq_update,
  output logic [11:0]      ints,
  output logic [24:0]      fracs,
  output logic             ref_doubled,
  output logic [4:0]       r_counter,
  output logic             prescaler
);

  logic [31:0]          word;
  logic                 cnt_ok, cnt_zero, latch;
  logic                 wr_en;
  logic [3:0]           wr_slot;
  logic [NUM_SLOTS-1:0] wr_onehot;
  logic [NUM_SLOTS-1:0] written;
  logic [31:0]          slots [NUM_SLOTS];

  adf4159_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .word     (word),
    .cnt_ok   (cnt_ok),
    .cnt_zero (cnt_zero),
    .latch    (latch)
  );

  assign wr_en   = latch & cnt_ok;
  assign wr_slot = slot_of(word);

  // One-hot of the slot being written, used for the power-up tracking.
  always_comb begin
    wr_onehot = '0;
    wr_onehot[wr_slot] = 1'b1;
  end

  // Register file and power-up tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      written   <= '0;
      init_done <= 1'b0;
    end else if (wr_en) begin
      slots[wr_slot] <= word;
      written        <= written | wr_onehot;
      if (((written | wr_onehot) & PWRUP_MASK) == PWRUP_MASK) init_done <= 1'b1;
    end
  end

  // Accepted word / malformed frame reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= wr_en;
      frame_err  <= latch & ~cnt_ok & ~cnt_zero;
      if (wr_en) word_data <= word;
    end
  end

  // Active fields move only on an R0 write, taking R1/R2 from their slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ints        <= '0;
      fracs       <= '0;
      ref_doubled <= 1'b0;
      r_counter   <= '0;
      prescaler   <= 1'b0;
      freq_update <= 1'b0;
    end else begin
      freq_update <= 1'b0;
      if (wr_en && word[2:0] == R0) begin
        ints        <= word[INT_MSB:INT_LSB];
        fracs       <= {word[FRAC_HI_MSB:FRAC_HI_LSB], slots[1][FRAC_LO_MSB:FRAC_LO_LSB]};
        ref_doubled <= slots[2][REF_DBL_BIT];
        r_counter   <= slots[2][RCNT_MSB:RCNT_LSB];
        prescaler   <= slots[2][PRESC_BIT];
        freq_update <= 1'b1;
      end
    end
  end

  // Registered readback; unused addresses read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_addr < 4'(NUM_SLOTS)) rd_data <= slots[rd_addr];
    else rd_data <= '0;
  end

endmodule

// File: tb/tb_adf4159_spi_rx.sv
// Self-checking bench for adf4159_spi_rx: directed vector table, random frames, stress and reset.
module tb_adf4159_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rd_addr, tb_addr, mon_addr;
  logic        mon_rd;
  logic [31:0] rd_data, word_data;
  logic        word_valid, frame_err, init_done, freq_update;
  logic [11:0] ints;
  logic [24:0] fracs;
  logic        ref_doubled, prescaler;
  logic [4:0]  r_counter;

  adf4159_spi_rx_if spi_if ();

  adf4159_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi(spi_if), .rd_addr(rd_addr), .rd_data(rd_data),
    .word_valid(word_valid), .word_data(word_data), .frame_err(frame_err),
    .init_done(init_done), .freq_update(freq_update), .ints(ints), .fracs(fracs),
    .ref_doubled(ref_doubled), .r_counter(r_counter), .prescaler(prescaler)
  );

  always #5 clk = ~clk;
  assign rd_addr = mon_rd ? mon_addr : tb_addr;

  int checks = 0;
  int failures = 0;
  int wv_cnt = 0, fe_cnt = 0, fu_cnt = 0;

  // Reference model of what the synthesizer holds.
  logic [31:0] m_slot [11];
  logic [10:0] m_wr;
  logic        m_init;
  logic [31:0] m_last;
  logic [11:0] m_ints;
  logic [24:0] m_fracs;
  logic        m_refd, m_pre;
  logic [4:0]  m_rcnt;
  logic [31:0] exp_q [$];

  logic        rb_pend = 1'b0;
  logic [31:0] rb_exp;

  typedef struct {
    string       nm;
    logic [63:0] bits;
    int          nbits;
    int          le_w;
    int          exp_wv;
    int          exp_fe;
    int          exp_fu;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int slot_idx(input logic [31:0] w);
    int a;
    a = int'(w[2:0]);
    if (a == 4 && w[6]) return 8;
    if ((a == 5 || a == 6) && w[23]) return a + 4;
    return a;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 11; i++) m_slot[i] = '0;
    m_wr = '0; m_init = 0; m_last = '0;
    m_ints = '0; m_fracs = '0; m_refd = 0; m_pre = 0; m_rcnt = '0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [63:0] bits, input int n);
    logic [31:0] w;
    int s;
    if (n != 32) return;
    w = bits[31:0];
    s = slot_idx(w);
    if (w[2:0] == 3'd0) begin
      m_ints  = w[26:15];
      m_fracs = {w[14:3], m_slot[1][27:15]};
      m_refd  = m_slot[2][20];
      m_rcnt  = m_slot[2][19:15];
      m_pre   = m_slot[2][22];
    end
    m_slot[s] = w;
    m_wr[s]   = 1'b1;
    m_init    = &m_wr[10:3];
    m_last    = w;
    exp_q.push_back(w);
  endtask

  // Pulse counting and live word check, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!rst) begin
      if (word_valid)  wv_cnt++;
      if (frame_err)   fe_cnt++;
      if (freq_update) fu_cnt++;
      if (rb_pend) begin
        rb_pend = 1'b0;
        chk($sformatf("readback_slot%0d", mon_addr), rd_data, rb_exp);
      end
      if (word_valid) begin
        chk("word_valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("word_data_live", word_data, w);
          if (mon_rd) begin
            mon_addr = 4'(slot_idx(w));
            rb_exp   = w;
            rb_pend  = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.spi_data = bits[i];
      cyc(2);
      spi_if.spi_clk = 1'b1;
      cyc(2);
      spi_if.spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [63:0] bits, input int n, input int le_w);
    send_bits(bits, n);
    spi_if.spi_le = 1'b1;
    cyc(le_w);
    spi_if.spi_le = 1'b0;
  endtask

  task automatic check_state(input string nm);
    chk({nm, ".word_data"}, word_data, m_last);
    chk({nm, ".ints"}, ints, m_ints);
    chk({nm, ".fracs"}, fracs, m_fracs);
    chk({nm, ".ref_doubled"}, ref_doubled, m_refd);
    chk({nm, ".r_counter"}, r_counter, m_rcnt);
    chk({nm, ".prescaler"}, prescaler, m_pre);
    chk({nm, ".init_done"}, init_done, m_init);
  endtask

  task automatic frame_chk(input string nm, input logic [63:0] bits, input int n,
                           input int le_w, input int ewv, input int efe, input int efu);
    int wv0, fe0, fu0;
    wv0 = wv_cnt; fe0 = fe_cnt; fu0 = fu_cnt;
    model_frame(bits, n);
    send(bits, n, le_w);
    cyc(8);
    chk({nm, ".word_valid"}, wv_cnt - wv0, ewv);
    chk({nm, ".frame_err"}, fe_cnt - fe0, efe);
    chk({nm, ".freq_update"}, fu_cnt - fu0, efu);
    check_state(nm);
  endtask

  task automatic read_slot(input int a, output logic [31:0] d);
    tb_addr = 4'(a);
    cyc(1);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_all_slots(input string nm);
    logic [31:0] d;
    for (int a = 0; a < 16; a++) begin
      read_slot(a, d);
      chk($sformatf("%s.slot%0d", nm, a), d, (a < 11) ? m_slot[a] : 32'h0);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, ".rd_data"}, rd_data, 0);
    chk({nm, ".pulses"}, {word_valid, frame_err, freq_update, init_done}, 0);
    chk({nm, ".word_data"}, word_data, 0);
    chk({nm, ".fields"}, {ints, fracs, ref_doubled, r_counter, prescaler}, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] rb;
    int n, wv0;

    spi_if.spi_clk = 0; spi_if.spi_data = 0; spi_if.spi_le = 0;
    tb_addr = '0; mon_addr = '0; mon_rd = 0;
    m_reset();
    #1 rst = 1'b1;
    cyc(3);
    check_outputs_zero("reset_init");
    rst = 1'b0;
    cyc(2);
    check_all_slots("reset_init");

    // Power-up load, double buffering, malformed frames.
    vecs.push_back('{"pwr0", 64'h7,        32, 2, 1, 0, 0});
    vecs.push_back('{"pwr1", 64'h6,        32, 2, 1, 0, 0});
    vecs.push_back('{"pwr2", 64'h800006,   32, 3, 1, 0, 0});
    vecs.push_back('{"pwr3", 64'h5,        32, 2, 1, 0, 0});
    vecs.push_back('{"pwr4", 64'h800005,   32, 2, 1, 0, 0});
    vecs.push_back('{"pwr5", 64'h104,      32, 4, 1, 0, 0});
    vecs.push_back('{"pwr6", 64'h144,      32, 2, 1, 0, 0});
    vecs.push_back('{"pwr7", 64'h1020403,  32, 2, 1, 0, 0});
    vecs.push_back('{"dbR2", 64'h700800A,  32, 2, 1, 0, 0});
    vecs.push_back('{"dbR1", 64'h71C8009,  32, 2, 1, 0, 0});
    vecs.push_back('{"dbR0", 64'h30312500, 32, 2, 1, 0, 1});
    vecs.push_back('{"short31", 64'h12345670, 31, 2, 0, 1, 0});
    vecs.push_back('{"long33", 64'h1_2345_6780, 33, 2, 0, 1, 0});
    vecs.push_back('{"le_only", 64'h0,       0, 3, 0, 0, 0});
    vecs.push_back('{"one_bit", 64'h1,       1, 2, 0, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      frame_chk(vecs[i].nm, vecs[i].bits, vecs[i].nbits, vecs[i].le_w,
                vecs[i].exp_wv, vecs[i].exp_fe, vecs[i].exp_fu);
      if (vecs[i].nm == "pwr6") chk("init_before_last", init_done, 0);
      if (vecs[i].nm == "pwr7") chk("init_after_last", init_done, 1);
      if (vecs[i].nm == "dbR1") chk("db_hold_ints", {ints, fracs}, 0);
    end
    read_slot(6, d);  chk("pwr.slot6", d, 32'h6);
    read_slot(10, d); chk("pwr.slot10", d, 32'h800006);
    read_slot(8, d);  chk("pwr.slot8", d, 32'h144);
    chk("db.ints", ints, 12'h062);
    chk("db.fracs", fracs, 25'h940E39);
    chk("db.r_counter", r_counter, 5'd1);
    chk("db.ref_pre", {ref_doubled, prescaler}, 2'b00);
    check_all_slots("directed");

    // Random frames against the model.
    for (int i = 0; i < 40; i++) begin
      rb = {$urandom, $urandom};
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : 32;
      frame_chk($sformatf("rnd%0d", i), rb, n, int'($urandom_range(2, 5)),
                (n == 32) ? 1 : 0, (n != 32 && n != 0) ? 1 : 0,
                (n == 32 && rb[2:0] == 3'd0) ? 1 : 0);
    end
    check_all_slots("random");

    // Back-to-back words at clk/4 with minimum LE width; live readback.
    mon_rd = 1'b1;
    wv0 = wv_cnt;
    for (int i = 0; i < 12; i++) begin
      rb = {32'h0, $urandom};
      model_frame(rb, 32);
      send(rb, 32, 2);
    end
    cyc(8);
    mon_rd = 1'b0;
    chk("stress.count", wv_cnt - wv0, 12);
    chk("stress.queue_empty", exp_q.size(), 0);
    check_state("stress");
    check_all_slots("stress");

    // Reset mid-frame, then a partial frame after release.
    send_bits(64'h3FF, 10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid");
    m_reset();
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check_all_slots("reset_mid");
    frame_chk("post_reset_partial", 64'h15, 5, 2, 0, 1, 0);
    frame_chk("post_reset_word", 64'h104, 32, 2, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
